// File: rtl/bip_control.sv
// Fetch/execute control unit for the 16-bit accumulator datapath.
// Holds the PC, sequences FETCH/EXEC against a synchronous program memory and decodes opcodes.
module bip_control #(
  parameter int PC_WIDTH      = 11,
  parameter int OPERAND_WIDTH = 11,
  parameter int OPCODE_WIDTH  = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_start,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] i_instr,
  output logic [PC_WIDTH-1:0]                   o_pc_addr,
  output logic [OPERAND_WIDTH-1:0]              o_operand,
  output logic [1:0]                            o_sel_a,
  output logic                                  o_sel_b,
  output logic                                  o_op,
  output logic                                  o_wr_acc,
  output logic                                  o_rd_ram,
  output logic                                  o_wr_ram,
  output logic                                  o_halted,
  output logic [CNT_WIDTH-1:0]                  o_instr_cnt
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);

  state_t                    state, next_state;
  logic [PC_WIDTH-1:0]       pc;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [OPCODE_WIDTH-1:0]   opcode;

  assign opcode      = i_instr[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
  assign o_pc_addr   = pc;
  assign o_instr_cnt = cnt;
  assign o_halted    = (state == HALT);

  // PC and counter advance only as an instruction retires at the end of EXEC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == EXEC) begin
        if (opcode != OP_HLT)
          pc <= pc + PC_WIDTH'(1);
        if (cnt != '1)
          cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    o_operand  = '0;
    o_sel_a    = 2'b00;
    o_sel_b    = 1'b0;
    o_op       = 1'b0;
    o_wr_acc   = 1'b0;
    o_rd_ram   = 1'b0;
    o_wr_ram   = 1'b0;

    case (state)
      IDLE:    if (i_start) next_state = FETCH;
      FETCH:   next_state = EXEC;
      EXEC:    next_state = (opcode == OP_HLT) ? HALT : FETCH;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase

    // A reset arriving during EXEC suppresses the strobes of the instruction it cancels.
    if (state == EXEC && !i_reset) begin
      o_operand = i_instr[OPERAND_WIDTH-1:0];
      case (opcode)
        OP_STO:  o_wr_ram = 1'b1;
        OP_LD: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
        end
        OP_LDI: begin
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b01;
        end
        OP_ADD, OP_SUB: begin
          o_rd_ram = 1'b1;
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
          o_op     = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          o_wr_acc = 1'b1;
          o_sel_a  = 2'b10;
          o_sel_b  = 1'b1;
          o_op     = (opcode == OP_SUBI);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
Control unit for the 16-bit accumulator datapath built around arit_unit: add/sub on accumulator and operand, i_OP 0 = add, 1 = sub.
- Holds the program counter and runs a fetch/execute sequence against a synchronous instruction memory.
- Decodes a 5-bit opcode and drives one cycle of datapath/data-RAM controls per instruction.
- Sits between program memory and the accumulator/arit_unit/data-RAM datapath.

Parameters:
PC_WIDTH, 11, program counter / instruction address width
OPERAND_WIDTH, 11, operand field width (instr[10:0])
OPCODE_WIDTH, 5, opcode field width (instr[15:11])
CNT_WIDTH, 16, executed-instruction counter width

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  synchronous reset, active-high
i_start  in  1  begin execution; sampled only in IDLE
i_instr  in  16  instruction word from program memory
o_pc_addr  out  PC_WIDTH  program memory address (= PC)
o_operand  out  OPERAND_WIDTH  i_instr[10:0], passed through during EXEC, else 0
o_sel_a  out  2  accumulator input mux: 00 data RAM, 01 immediate (sign-extended operand), 10 arit_unit result
o_sel_b  out  1  arit_unit i_DATA mux: 0 data RAM, 1 immediate
o_op  out  1  to arit_unit i_OP: 0 add, 1 subtract
o_wr_acc  out  1  accumulator write enable
o_rd_ram  out  1  data RAM read enable (combinational read, same cycle)
o_wr_ram  out  1  data RAM write of accumulator at address o_operand
o_halted  out  1  high while in HALT
o_instr_cnt  out  CNT_WIDTH  executed instructions, HLT included

Behaviour:
- Reset: synchronous and active-high. On any edge with i_reset=1: state IDLE, PC=0, o_instr_cnt=0, all control outputs 0, o_halted=0. Reset overrides every other input, including mid-EXEC; no write strobe is issued in the reset cycle.
- States: IDLE, FETCH, EXEC, HALT.
  - IDLE: i_start=1 goes to FETCH, else stay.
  - FETCH: presents PC on o_pc_addr. Memory returns i_instr in the next cycle. Always goes to EXEC.
  - EXEC: decodes i_instr combinationally and drives controls for exactly this one cycle. Then goes to FETCH, or to HALT if opcode is HLT.
  - HALT: all controls 0, o_halted=1, PC frozen. Left only via reset; i_start is ignored.
- Timing: one instruction per 2 cycles (FETCH+EXEC). Throughput 0.5 instr/cycle.
- o_pc_addr = PC in all states.
- PC increments at the end of EXEC for every opcode except HLT. It wraps 2^PC_WIDTH-1 -> 0 with no flag.
- o_instr_cnt increments at the end of each EXEC, HLT included. It saturates at all-ones.
- Control outputs are 0 in IDLE, FETCH and HALT. In EXEC, unlisted signals are 0:
  - 00000 HLT: none
  - 00001 STO: wr_ram
  - 00010 LD: rd_ram, wr_acc, sel_a=00
  - 00011 LDI: wr_acc, sel_a=01
  - 00100 ADD: rd_ram, wr_acc, sel_a=10, sel_b=0, op=0
  - 00101 ADDI: wr_acc, sel_a=10, sel_b=1, op=0
  - 00110 SUB: rd_ram, wr_acc, sel_a=10, sel_b=0, op=1
  - 00111 SUBI: wr_acc, sel_a=10, sel_b=1, op=1
  - others: NOP; no strobes, PC increments, counter increments
- At most one of wr_acc/wr_ram is high in any cycle. wr_acc and wr_ram are never high outside EXEC.
- Control outputs are registered-state decode: glitch-free relative to the clock, changing only after edges.
- i_start held high across IDLE->FETCH has no further effect.

Test Plan:
- Reset then i_start pulse; program LDI 5, ADDI 3, SUBI 10, HLT at addresses 0..3 -> sequence of o_pc_addr 0,0,1,1,2,2,3,3. In the ADDI EXEC: sel_a=10, sel_b=1, op=0, operand=3. In the SUBI EXEC: op=1, operand=10. Then o_halted=1, PC stays 3, o_instr_cnt=4.
- Program LD 7, ADD 8, STO 9, HLT -> in EXEC: rd_ram=1 with operand 7, then 8; wr_ram=1 with operand 9, wr_acc=0. No strobes during FETCH cycles.
- Opcode 11111 at address 0, HLT at address 1 -> no strobes for the 11111 instruction. PC advances to 1 and halts there; o_instr_cnt=2.
- i_reset asserted during EXEC of STO -> wr_ram stays 0 from that edge. Next cycle state IDLE, PC=0, counter=0, o_halted=0. Pulsing i_start in HALT before the reset causes no change.
- PC wrap: memory filled with NOP, run 2048 instructions -> o_pc_addr goes 2047 -> 0. o_instr_cnt=2048 when PC first returns to 0.
- Counter saturation with CNT_WIDTH=4: run 20 NOPs -> o_instr_cnt holds 15.
